passcode_lock: RTL and testbench
================================

PASSCODE_LOCK -- requirements
Module: passcode_lock

Interface
REQ-001 SHALL have parameter DIGIT_W, default 4, width of one keypad digit.
REQ-002 SHALL have parameter CODE_LEN, default 4, digits per passcode (2..8).
REQ-003 SHALL have parameter MAX_TRIES, default 3, consecutive failed entries that trigger lockout.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16, lockout duration in clk cycles.
REQ-005 SHALL have parameter DEFAULT_CODE, default {1,8,6,5} (first digit first), passcode loaded at reset.
REQ-006 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-008 SHALL have port digit_valid, input, 1 bit, qualifies digit for one cycle.
REQ-009 SHALL have port digit, input, DIGIT_W bits, keypad digit value.
REQ-010 SHALL have port clear, input, 1 bit, aborts partial entry or programming.
REQ-011 SHALL have port prog_en, input, 1 bit, routes digits to code programming while OPEN.
REQ-012 SHALL have port relock, input, 1 bit, leaves OPEN.
REQ-013 SHALL have port unlocked, output, 1 bit, high while in OPEN.
REQ-014 SHALL have port fail, output, 1 bit, one-cycle pulse on a wrong complete entry.
REQ-015 SHALL have port locked_out, output, 1 bit, high while in LOCKOUT.
REQ-016 SHALL have port prog_done, output, 1 bit, one-cycle pulse when a new code commits.
REQ-017 SHALL have port digit_cnt, output, clog2(CODE_LEN+1) bits, digits accepted in the current entry or program sequence.

Function
REQ-018 SHALL implement states ENTRY, OPEN, LOCKOUT; all outputs registered.
REQ-019 In ENTRY, each digit_valid cycle SHALL compare digit to stored code[digit_cnt], OR any mismatch into a sticky error flag, and increment digit_cnt.
REQ-020 On the CODE_LEN-th digit with no mismatch SHALL enter OPEN; unlocked rises the next cycle; fail count clears; digit_cnt returns to 0.
REQ-021 On the CODE_LEN-th digit with any mismatch SHALL pulse fail for one cycle (next cycle), increment fail count, and return digit_cnt to 0.
REQ-022 When fail count reaches MAX_TRIES, SHALL enter LOCKOUT in the same cycle as the fail pulse; fail count clears.
REQ-023 LOCKOUT SHALL last exactly LOCK_CYCLES cycles, ignore digit_valid, clear, prog_en and relock, then return to ENTRY.
REQ-024 clear in ENTRY SHALL zero digit_cnt and the error flag without counting a failure; clear wins over a simultaneous digit_valid.
REQ-025 In OPEN with prog_en=1, each digit_valid SHALL write digit into a shadow code at index digit_cnt; digit_valid with prog_en=0 SHALL be ignored.
REQ-026 After CODE_LEN programmed digits, SHALL copy the shadow code to the stored code atomically, pulse prog_done, and remain OPEN.
REQ-027 clear in OPEN SHALL discard the partial shadow code and keep the stored code.
REQ-028 relock in OPEN SHALL go to ENTRY next cycle, discarding any partial programming; relock wins over a simultaneous digit_valid.
REQ-029 A digit_valid arriving without any gap after a completing digit SHALL be processed as digit 0 of the next sequence (no dead cycle).

Reset
REQ-030 reset SHALL force ENTRY, stored code=DEFAULT_CODE, digit_cnt=0, fail count=0, error flag=0, lockout timer=0.
REQ-031 During reset, unlocked, fail, locked_out and prog_done SHALL be 0; a reset during OPEN, LOCKOUT or programming SHALL abandon that operation.

Structure
REQ-032 SHALL place the state enum and default-parameter constants in package passcode_lock_pkg.
REQ-033 SHALL use one sub-module, lockout_timer (load/count-down/done), for LOCKOUT duration.

Verification
REQ-034 Reset, digits 1,8,6,5 -> unlocked=1 the cycle after the 4th digit; fail stays 0.
REQ-035 Digits 1,8,6,4 three times -> three fail pulses; locked_out=1 from the 3rd for 16 cycles; digits 1,8,6,5 during lockout ignored; after lockout, 1,8,6,5 -> unlocked.
REQ-036 OPEN, prog_en=1, digits 2,4,6,8 -> prog_done pulse; relock; 1,8,6,5 -> fail; 2,4,6,8 -> unlocked.
REQ-037 Digits 1,8 then clear with a simultaneous digit_valid -> digit_cnt=0, no fail; 1,8,6,5 -> unlocked.
REQ-038 OPEN, program 9,9 then relock -> stored code unchanged; reset mid-LOCKOUT -> locked_out=0, code=1,8,6,5.

Source files
------------

// File: rtl/passcode_lock_pkg.sv
// Shared types and default constants for the keypad passcode lock.
package passcode_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_e;

  localparam int DEF_DIGIT_W     = 4;
  localparam int DEF_CODE_LEN    = 4;
  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_LOCK_CYCLES = 16;
  // First digit sits in the most significant nibble.
  localparam logic [DEF_CODE_LEN*DEF_DIGIT_W-1:0] DEF_CODE = {4'd1, 4'd8, 4'd6, 4'd5};

endpackage

// File: rtl/lockout_timer.sv
// Down-counter that times the lockout window; done_o is high once the count hits zero.
module lockout_timer
  import passcode_lock_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/passcode_lock.sv
// Keypad passcode lock: digit-by-digit entry, failed-try lockout and in-place code programming.
module passcode_lock
  import passcode_lock_pkg::*;
#(
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int CODE_LEN    = DEF_CODE_LEN,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = DEF_CODE
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              digit_valid,
  input  logic [DIGIT_W-1:0]                digit,
  input  logic                              clear,
  input  logic                              prog_en,
  input  logic                              relock,
  output logic                              unlocked,
  output logic                              fail,
  output logic                              locked_out,
  output logic                              prog_done,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt
);

  localparam int CW  = $clog2(CODE_LEN+1);
  localparam int IW  = $clog2(CODE_LEN);
  localparam int TRW = $clog2(MAX_TRIES+1);
  localparam int TMW = $clog2(LOCK_CYCLES+1);
  localparam logic [CW-1:0]  LAST_CNT  = CW'(CODE_LEN-1);
  localparam logic [TRW-1:0] LAST_TRY  = TRW'(MAX_TRIES-1);
  localparam logic [TMW-1:0] LOCK_LOAD = TMW'(LOCK_CYCLES-1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [TRW-1:0]     tries_q, tries_d;
  logic               unlocked_q, fail_q, locked_out_q, prog_done_q;
  logic               fail_d, prog_done_d;
  logic               commit, shadow_we, timer_load, timer_done;
  logic [DIGIT_W-1:0] code_q   [CODE_LEN];
  logic [DIGIT_W-1:0] shadow_q [CODE_LEN];
  logic [IW-1:0]      idx;
  logic               mismatch;

  assign idx      = cnt_q[IW-1:0];
  assign mismatch = (digit != code_q[idx]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    tries_d     = tries_q;
    fail_d      = 1'b0;
    prog_done_d = 1'b0;
    commit      = 1'b0;
    shadow_we   = 1'b0;
    timer_load  = 1'b0;
    unique case (state_q)
      ST_ENTRY: begin
        if (clear) begin
          cnt_d = '0;
          err_d = 1'b0;
        end else if (digit_valid) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            err_d = 1'b0;
            if (err_q || mismatch) begin
              fail_d = 1'b1;
              if (tries_q == LAST_TRY) begin
                tries_d    = '0;
                state_d    = ST_LOCKOUT;
                timer_load = 1'b1;
              end else begin
                tries_d = tries_q + TRW'(1);
              end
            end else begin
              tries_d = '0;
              state_d = ST_OPEN;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
            err_d = err_q | mismatch;
          end
        end
      end
      ST_OPEN: begin
        if (relock) begin
          state_d = ST_ENTRY;
          cnt_d   = '0;
        end else if (clear) begin
          cnt_d = '0;
        end else if (digit_valid && prog_en) begin
          shadow_we = 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d       = '0;
            commit      = 1'b1;
            prog_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_LOCKOUT: begin
        if (timer_done) begin
          state_d = ST_ENTRY;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ENTRY;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      tries_q      <= '0;
      unlocked_q   <= 1'b0;
      fail_q       <= 1'b0;
      locked_out_q <= 1'b0;
      prog_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      tries_q      <= tries_d;
      unlocked_q   <= (state_d == ST_OPEN);
      fail_q       <= fail_d;
      locked_out_q <= (state_d == ST_LOCKOUT);
      prog_done_q  <= prog_done_d;
    end
  end

  // The final digit bypasses the shadow so the whole code swaps in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CODE_LEN; i++)
        code_q[i] <= DEFAULT_CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end else if (commit) begin
      for (int i = 0; i < CODE_LEN-1; i++)
        code_q[i] <= shadow_q[i];
      code_q[CODE_LEN-1] <= digit;
    end
  end

  always_ff @(posedge clk) begin
    if (shadow_we) shadow_q[idx] <= digit;
  end

  lockout_timer #(.CNT_W(TMW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (LOCK_LOAD),
    .en_i       (state_q == ST_LOCKOUT),
    .done_o     (timer_done)
  );

  assign unlocked   = unlocked_q;
  assign fail       = fail_q;
  assign locked_out = locked_out_q;
  assign prog_done  = prog_done_q;
  assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_passcode_lock.sv
// Vector-table bench for passcode_lock with a queue of expected outputs per driven cycle.
module tb_passcode_lock;

  logic       clk = 1'b0;
  logic       reset, dv, clr, prg, rel;
  logic [3:0] dg;
  logic       unl, fl, lo, pd;
  logic [2:0] cnt;

  always #5 clk = ~clk;

  passcode_lock dut (
    .clk(clk), .reset(reset), .digit_valid(dv), .digit(dg), .clear(clr),
    .prog_en(prg), .relock(rel), .unlocked(unl), .fail(fl),
    .locked_out(lo), .prog_done(pd), .digit_cnt(cnt)
  );

  typedef struct {
    bit dv; logic [3:0] d; bit clr, prg, rel;
    bit unl, fl, lo, pd; logic [2:0] cnt;
  } vec_t;

  typedef struct {
    bit unl, fl, lo, pd; logic [2:0] cnt; int idx;
  } exp_t;

  localparam int UNL = 0, FAILK = 1, LOCKK = 2;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input bit v_dv, input int d, input bit c, input bit p, input bit r,
                     input bit e_unl, input bit e_fl, input bit e_lo, input bit e_pd, input int e_cnt);
    vec_t v;
    v.dv = v_dv; v.d = d[3:0]; v.clr = c; v.prg = p; v.rel = r;
    v.unl = e_unl; v.fl = e_fl; v.lo = e_lo; v.pd = e_pd; v.cnt = e_cnt[2:0];
    tbl.push_back(v);
  endtask

  task automatic add_code(input int a, input int b, input int c, input int e, input int kind);
    add(1, a, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, b, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, c, 0, 0, 0, 0, 0, 0, 0, 3);
    add(1, e, 0, 0, 0, kind == UNL, kind != UNL, kind == LOCKK, 0, 0);
  endtask

  task automatic add_prog(input int a, input int b, input int c, input int e);
    add(1, a, 0, 1, 0, 1, 0, 0, 0, 1);
    add(1, b, 0, 1, 0, 1, 0, 0, 0, 2);
    add(1, c, 0, 1, 0, 1, 0, 0, 0, 3);
    add(1, e, 0, 1, 0, 1, 0, 0, 1, 0);
  endtask

  task automatic run_table();
    exp_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      dv = tbl[i].dv; dg = tbl[i].d; clr = tbl[i].clr; prg = tbl[i].prg; rel = tbl[i].rel;
      e.unl = tbl[i].unl; e.fl = tbl[i].fl; e.lo = tbl[i].lo; e.pd = tbl[i].pd;
      e.cnt = tbl[i].cnt; e.idx = step;
      sb.push_back(e);
      step++;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("step%0d.unlocked", e.idx),   32'(unl), 32'(e.unl));
      chk($sformatf("step%0d.fail", e.idx),       32'(fl),  32'(e.fl));
      chk($sformatf("step%0d.locked_out", e.idx), 32'(lo),  32'(e.lo));
      chk($sformatf("step%0d.prog_done", e.idx),  32'(pd),  32'(e.pd));
      chk($sformatf("step%0d.digit_cnt", e.idx),  32'(cnt), 32'(e.cnt));
    end
    tbl.delete();
    dv = 0; clr = 0; prg = 0; rel = 0; dg = 0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".unlocked"},   32'(unl), 0);
    chk({nm, ".fail"},       32'(fl),  0);
    chk({nm, ".locked_out"}, 32'(lo),  0);
    chk({nm, ".prog_done"},  32'(pd),  0);
    chk({nm, ".digit_cnt"},  32'(cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seq[4];
    seq = '{1, 8, 6, 5};
    reset = 1; dv = 0; clr = 0; prg = 0; rel = 0; dg = 0;
    @(posedge clk); @(posedge clk); #1;
    chk_idle("in_reset");
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    chk_idle("after_reset");

    // Correct entry, then relock.
    add_code(1, 8, 6, 5, UNL);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Clear beats a simultaneous digit, no failure counted.
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 8, 0, 0, 0, 0, 0, 0, 0, 2);
    add(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    add_code(1, 8, 6, 5, UNL);
    add(1, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    // Program 2,4,6,8; old code now fails, new one opens.
    add_prog(2, 4, 6, 8);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_code(1, 8, 6, 5, FAILK);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_code(2, 4, 6, 8, UNL);
    // Partial programming discarded by clear and by relock.
    add(1, 9, 0, 1, 0, 1, 0, 0, 0, 1);
    add(1, 9, 0, 1, 0, 1, 0, 0, 0, 2);
    add(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 9, 0, 1, 0, 1, 0, 0, 0, 1);
    add(1, 9, 0, 1, 0, 1, 0, 0, 0, 2);
    add(1, 9, 0, 1, 1, 0, 0, 0, 0, 0);
    add_code(2, 4, 6, 8, UNL);
    add_prog(1, 8, 6, 5);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Three back-to-back wrong entries trigger a 16-cycle lockout.
    add_code(1, 8, 6, 4, FAILK);
    add_code(1, 8, 6, 4, FAILK);
    add_code(1, 8, 6, 4, LOCKK);
    for (int k = 0; k < 15; k++)
      add(1, seq[k % 4], k == 5, k == 6, k == 7, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_code(1, 8, 6, 5, UNL);
    // New code, then lockout that reset will interrupt.
    add_prog(2, 4, 6, 8);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_code(1, 8, 6, 5, FAILK);
    add_code(1, 8, 6, 5, FAILK);
    add_code(1, 8, 6, 5, LOCKK);
    for (int k = 0; k < 3; k++)
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    run_table();

    chk("pre_reset.locked_out", 32'(lo), 1);
    @(negedge clk); #2;
    reset = 1;
    #1;
    chk_idle("async_reset");
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    chk_idle("post_lockout_reset");
    add_code(1, 8, 6, 5, UNL);
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
